// File: rtl/icache_assoc.sv
// Set-associative instruction cache: per-set round-robin replacement, one-block
// refill over a request/response handshake, and a single-cycle whole-cache flush.
module icache_assoc #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 4,
  parameter int WAYS        = 2
) (
  input  logic                          clkIn,
  input  logic                          resetNIn,
  input  logic                          flushIn,
  input  logic                          instrInValid,
  input  logic [ADDR_WIDTH-1:0]         instrAddrIn,
  output logic                          readyOut,
  output logic                          instrOutValid,
  output logic [31:0]                   instrOut,
  output logic                          missOut,
  output logic                          memReqValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memReqAddr,
  input  logic                          memDataValid,
  input  logic [(8<<BLOCK_WIDTH)-1:0]   memDataIn
);

  localparam int BW    = 8 << BLOCK_WIDTH;
  localparam int WORDS = (1 << BLOCK_WIDTH) / 4;
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - BLOCK_WIDTH - SET_WIDTH;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {IDLE, REFILL} state_t;

  // Handshake: a request is taken on any edge where instrInValid && readyOut;
  // memReqValid stays high until the edge that samples memDataValid.
  state_t                  state_q, state_d;
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAY_W-1:0]        ptr_q   [SETS];
  logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
  logic [BW-1:0]           data_q  [SETS][WAYS];
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    flushed_q;
  logic                    out_valid_q, miss_q;
  logic [31:0]             out_data_q;

  logic [SET_WIDTH-1:0]    req_set, fill_set;
  logic [TAG_W-1:0]        req_tag, fill_tag;
  logic                    hit, multi_hit, vic_found;
  logic [WAY_W-1:0]        hit_way, vic_way;
  logic                    hit_take, miss_take, do_fill, install;

  function automatic logic [31:0] word_sel(input logic [BW-1:0] blk,
                                           input logic [BLOCK_WIDTH-1:0] offs);
    word_sel = '0;
    for (int w = 0; w < WORDS; w++)
      if (int'(offs >> 2) == w) word_sel = blk[w*32 +: 32];
  endfunction

  assign req_set  = instrAddrIn[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign req_tag  = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];
  assign fill_set = addr_q[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign fill_tag = addr_q[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];

  always_comb begin
    hit       = 1'b0;
    multi_hit = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        if (hit) multi_hit = 1'b1;
        else begin
          hit     = 1'b1;
          hit_way = WAY_W'(w);
        end
      end
    end
  end

  // Prefer an empty way; only fall back to the round-robin pointer when full.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = ptr_q[fill_set];
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[fill_set][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hit_take  = 1'b0;
    miss_take = 1'b0;
    do_fill   = 1'b0;
    readyOut    = (state_q == IDLE);
    memReqValid = (state_q == REFILL);
    case (state_q)
      IDLE: begin
        if (instrInValid) begin
          if (hit && !flushIn) hit_take = 1'b1;
          else begin
            miss_take = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        if (memDataValid) begin
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush seen at any point during the refill keeps the returning block out.
  assign install = do_fill && !flushed_q && !flushIn;

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      flushed_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      miss_q      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= hit_take | do_fill;
      miss_q      <= miss_take;
      if (miss_take) addr_q <= instrAddrIn;
      if (hit_take)
        out_data_q <= word_sel(data_q[req_set][hit_way], instrAddrIn[BLOCK_WIDTH-1:0]);
      else if (do_fill)
        out_data_q <= word_sel(memDataIn, addr_q[BLOCK_WIDTH-1:0]);
      if (miss_take) flushed_q <= 1'b0;
      else if (state_q == REFILL && flushIn) flushed_q <= 1'b1;
      if (flushIn) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          ptr_q[s]   <= '0;
        end
      end else if (install) begin
        valid_q[fill_set][vic_way] <= 1'b1;
        ptr_q[fill_set] <= (ptr_q[fill_set] == WAY_W'(WAYS-1)) ? '0
                                                                : ptr_q[fill_set] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (install) begin
      tag_q[fill_set][vic_way]  <= fill_tag;
      data_q[fill_set][vic_way] <= memDataIn;
    end
  end

  assign instrOutValid = out_valid_q;
  assign instrOut      = out_data_q;
  assign missOut       = miss_q;
  assign memReqAddr    = addr_q[ADDR_WIDTH-1:BLOCK_WIDTH];

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: cold miss, hits, replacement, flushes, reset mid-refill.
module tb_icache_assoc;

  logic         clk, rst_n, flush, instr_valid, mvalid;
  logic [16:0]  instr_addr;
  logic         rdy, ov, miss, mreq;
  logic [31:0]  instr;
  logic [12:0]  maddr;
  logic [127:0] mdata;
  int           n_checks, n_bad;

  icache_assoc dut (
    .clkIn(clk), .resetNIn(rst_n), .flushIn(flush),
    .instrInValid(instr_valid), .instrAddrIn(instr_addr),
    .readyOut(rdy), .instrOutValid(ov), .instrOut(instr), .missOut(miss),
    .memReqValid(mreq), .memReqAddr(maddr),
    .memDataValid(mvalid), .memDataIn(mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n)
      assert (!dut.multi_hit) else $error("FAIL multi_hit two ways match tag");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [16:0] a);
    return {8'hC0, 3'b000, a[16:4], 6'b000000, a[3:2]};
  endfunction

  function automatic logic [127:0] block_of(input logic [16:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = word_of({a[16:4], 4'(i*4)});
    return b;
  endfunction

  task automatic do_miss(input string tg, input logic [16:0] a, input logic [127:0] blk,
                         input int dly, input bit fl_req, input bit fl_mid,
                         input logic [31:0] exp);
    instr_valid = 1'b1; instr_addr = a; flush = fl_req;
    check({tg, "_ready"}, 32'(rdy), 32'd1);
    tick;
    instr_valid = 1'b0; flush = 1'b0;
    check({tg, "_miss"}, 32'(miss), 32'd1);
    check({tg, "_memreq"}, 32'(mreq), 32'd1);
    check({tg, "_memaddr"}, 32'(maddr), 32'(a[16:4]));
    check({tg, "_busy"}, 32'(rdy), 32'd0);
    for (int i = 0; i < dly; i++) begin
      if (i == 0 && fl_mid) flush = 1'b1;
      tick;
      flush = 1'b0;
      if (i == 0) check({tg, "_miss_pulse"}, 32'(miss), 32'd0);
      check({tg, "_memreq_hold"}, 32'(mreq), 32'd1);
    end
    mvalid = 1'b1; mdata = blk;
    tick;
    mvalid = 1'b0;
    check({tg, "_ovalid"}, 32'(ov), 32'd1);
    check({tg, "_word"}, instr, exp);
    check({tg, "_memreq_low"}, 32'(mreq), 32'd0);
    check({tg, "_ready_back"}, 32'(rdy), 32'd1);
  endtask

  task automatic do_hit(input string tg, input logic [16:0] a);
    instr_valid = 1'b1; instr_addr = a;
    tick;
    instr_valid = 1'b0;
    check({tg, "_ovalid"}, 32'(ov), 32'd1);
    check({tg, "_word"}, instr, word_of(a));
    check({tg, "_nomiss"}, 32'(miss), 32'd0);
    check({tg, "_nomemreq"}, 32'(mreq), 32'd0);
  endtask

  initial begin
    logic [127:0] cold_blk;
    n_checks = 0; n_bad = 0;
    rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr_addr = '0;
    mvalid = 1'b0; mdata = '0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(rdy), 32'd1);
    check("rst_ovalid", 32'(ov), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_memreq", 32'(mreq), 32'd0);
    check("rst_memaddr", 32'(maddr), 32'd0);
    tick;

    // Cold miss: word1 of block 0x0010 overridden with a recognisable pattern
    cold_blk = block_of(17'h00100);
    cold_blk[63:32] = 32'hDEADBEEF;
    do_miss("cold", 17'h00104, cold_blk, 3, 1'b0, 1'b0, 32'hDEADBEEF);

    // Back-to-back hits on the freshly filled block
    instr_valid = 1'b1; instr_addr = 17'h00108;
    tick;
    check("b2b0_ovalid", 32'(ov), 32'd1);
    check("b2b0_word", instr, word_of(17'h00108));
    check("b2b0_memreq", 32'(mreq), 32'd0);
    instr_addr = 17'h0010C;
    tick;
    instr_valid = 1'b0;
    check("b2b1_ovalid", 32'(ov), 32'd1);
    check("b2b1_word", instr, word_of(17'h0010C));
    check("b2b1_memreq", 32'(mreq), 32'd0);
    tick;
    check("idle_ovalid", 32'(ov), 32'd0);

    // Replacement in set 0: way0=tag1, way1=tag2, then tag3 evicts way0
    do_hit("rep_100", 17'h00100);
    do_miss("rep_200", 17'h00200, block_of(17'h00200), 0, 1'b0, 1'b0, word_of(17'h00200));
    do_miss("rep_300", 17'h00300, block_of(17'h00300), 1, 1'b0, 1'b0, word_of(17'h00300));
    do_hit("rep_200hit", 17'h00200);
    do_miss("rep_100m", 17'h00100, block_of(17'h00100), 0, 1'b0, 1'b0, word_of(17'h00100));
    do_hit("rep_300hit", 17'h00300);
    do_miss("rep_200m", 17'h00204, block_of(17'h00200), 0, 1'b0, 1'b0, word_of(17'h00204));

    // Flush during refill: word returned, nothing installed, everything gone
    do_miss("flr", 17'h00400, block_of(17'h00400), 2, 1'b0, 1'b1, word_of(17'h00400));
    do_miss("flr_400", 17'h00400, block_of(17'h00400), 0, 1'b0, 1'b0, word_of(17'h00400));
    do_miss("flr_200", 17'h00200, block_of(17'h00200), 0, 1'b0, 1'b0, word_of(17'h00200));

    // Reset mid-refill
    do_miss("pre_108", 17'h00108, block_of(17'h00100), 0, 1'b0, 1'b0, word_of(17'h00108));
    do_hit("pre_108hit", 17'h00108);
    instr_valid = 1'b1; instr_addr = 17'h00500;
    tick;
    instr_valid = 1'b0;
    check("rmr_memreq_up", 32'(mreq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmr_memreq_drop", 32'(mreq), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    check("rmr_ready", 32'(rdy), 32'd1);
    mvalid = 1'b1; mdata = block_of(17'h00500);
    tick;
    mvalid = 1'b0;
    check("rmr_stray_ovalid", 32'(ov), 32'd0);
    check("rmr_stray_memreq", 32'(mreq), 32'd0);
    do_miss("rmr_108", 17'h00108, block_of(17'h00100), 1, 1'b0, 1'b0, word_of(17'h00108));

    // Flush together with a request to a resident line
    do_miss("flq", 17'h00104, block_of(17'h00100), 1, 1'b1, 1'b0, word_of(17'h00104));
    do_hit("flq_108hit", 17'h00108);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
